// File: rtl/rastreador_pkg.sv
// rastreador_pkg: shared types and default sizing for the windowed
// max/min tracker (rastreador_extremos) and its magnitude comparator.
//   estado_t       : window FSM states
//   LARGURA_PADRAO : default sample width
//   JANELA_PADRAO  : default samples per window
package rastreador_pkg;

  localparam int LARGURA_PADRAO = 4;
  localparam int JANELA_PADRAO  = 8;

  typedef enum logic [1:0] {
    VAZIO      = 2'd0,  // no sample in the window yet
    ACUMULANDO = 2'd1,  // at least one sample accepted
    PUBLICANDO = 2'd2   // one-cycle publish of the window extremes
  } estado_t;

endpackage

// File: rtl/comparador_magnitude.sv
// comparador_magnitude: purely combinational magnitude comparator, A vs B.
// Ports:
//   A, B  in  [LARGURA-1:0]  operands
//   igual out                A == B
//   maior out                A >  B
//   menor out                A <  B
// Build option: RASTREADOR_SINAL_EN defined -> operands are two's-complement
// signed; otherwise they are compared as unsigned.
module comparador_magnitude
  import rastreador_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  output logic               igual,
  output logic               maior,
  output logic               menor
);

  assign igual = (A == B);

`ifdef RASTREADOR_SINAL_EN
  assign maior = ($signed(A) > $signed(B));
  assign menor = ($signed(A) < $signed(B));
`else
  assign maior = (A > B);
  assign menor = (A < B);
`endif

endmodule

// File: rtl/rastreador_extremos.sv
// rastreador_extremos: windowed max/min tracker. Accepts samples over a
// valid/ready handshake, keeps running extremes, and every JANELA accepted
// samples publishes them for one cycle before starting a new window.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low reset (0 = reset)
//   valido_in    in   sample valid
//   dado         in   [LARGURA-1:0] sample
//   pronto_out   out  ready; accept = valido_in && pronto_out
//   limpar       in   synchronous abort of the current window
//   maximo       out  [LARGURA-1:0] last published window maximum
//   minimo       out  [LARGURA-1:0] last published window minimum
//   valido_out   out  one-cycle publish strobe
//   novo_maximo  out  pulse: last accepted sample set a new running max
//   novo_minimo  out  pulse: last accepted sample set a new running min
//   contagem     out  samples accepted in the current window
// Build option: RASTREADOR_SINAL_EN selects signed comparison (see
// comparador_magnitude); the default build compares unsigned.
module rastreador_extremos
  import rastreador_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int JANELA  = JANELA_PADRAO
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valido_in,
  input  logic [LARGURA-1:0]          dado,
  output logic                        pronto_out,
  input  logic                        limpar,
  output logic [LARGURA-1:0]          maximo,
  output logic [LARGURA-1:0]          minimo,
  output logic                        valido_out,
  output logic                        novo_maximo,
  output logic                        novo_minimo,
  output logic [$clog2(JANELA+1)-1:0] contagem
);

  localparam int CW = $clog2(JANELA+1);
  localparam logic [CW-1:0] ULTIMO = CW'(JANELA - 1);

  estado_t              estado_q, estado_d;
  logic [LARGURA-1:0]   max_run_q, max_run_d;
  logic [LARGURA-1:0]   min_run_q, min_run_d;
  logic [LARGURA-1:0]   maximo_q, maximo_d;
  logic [LARGURA-1:0]   minimo_q, minimo_d;
  logic [CW-1:0]        cont_q, cont_d;
  logic                 nmax_q, nmax_d;
  logic                 nmin_q, nmin_d;

  logic aceita;
  logic limpa_ativo;
  logic fecha_janela;

  logic max_igual, max_maior, max_menor;
  logic min_igual, min_maior, min_menor;
  logic sinal_unused;

  comparador_magnitude #(.LARGURA(LARGURA)) u_cmp_max (
    .A     (dado),
    .B     (max_run_q),
    .igual (max_igual),
    .maior (max_maior),
    .menor (max_menor)
  );

  comparador_magnitude #(.LARGURA(LARGURA)) u_cmp_min (
    .A     (dado),
    .B     (min_run_q),
    .igual (min_igual),
    .maior (min_maior),
    .menor (min_menor)
  );

  // Only strict greater/less drive updates; equal values leave extremes alone.
  assign sinal_unused = &{1'b0, max_igual, max_menor, min_igual, min_maior};

  // limpar outranks a same-cycle sample, but cannot interrupt a publish.
  assign limpa_ativo  = limpar && (estado_q != PUBLICANDO);
  assign aceita       = valido_in && pronto_out && !limpar;
  assign fecha_janela = aceita && (estado_q == ACUMULANDO) && (cont_q == ULTIMO);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q <= VAZIO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      VAZIO: begin
        if (aceita) estado_d = ACUMULANDO;
      end
      ACUMULANDO: begin
        if (limpa_ativo)       estado_d = VAZIO;
        else if (fecha_janela) estado_d = PUBLICANDO;
      end
      PUBLICANDO: estado_d = VAZIO;
      default:    estado_d = VAZIO;
    endcase
  end

  // FSM outputs
  always_comb begin
    pronto_out = reset && (estado_q != PUBLICANDO);
    valido_out = (estado_q == PUBLICANDO);
  end

  // Datapath next-state: running extremes, count, pulses, published values.
  always_comb begin
    max_run_d = max_run_q;
    min_run_d = min_run_q;
    cont_d    = cont_q;
    nmax_d    = 1'b0;
    nmin_d    = 1'b0;
    maximo_d  = maximo_q;
    minimo_d  = minimo_q;
    if (limpa_ativo) begin
      max_run_d = '0;
      min_run_d = '0;
      cont_d    = '0;
    end else if (aceita) begin
      if (estado_q == VAZIO) begin
        max_run_d = dado;
        min_run_d = dado;
        nmax_d    = 1'b1;
        nmin_d    = 1'b1;
        cont_d    = CW'(1);
      end else begin
        if (max_maior) begin
          max_run_d = dado;
          nmax_d    = 1'b1;
        end
        if (min_menor) begin
          min_run_d = dado;
          nmin_d    = 1'b1;
        end
        cont_d = cont_q + CW'(1);
      end
      // Published values are captured at the closing edge so they appear in
      // the same cycle as valido_out, already including the last sample.
      if (fecha_janela) begin
        maximo_d = max_run_d;
        minimo_d = min_run_d;
      end
    end else if (estado_q == PUBLICANDO) begin
      cont_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      max_run_q <= '0;
      min_run_q <= '0;
      maximo_q  <= '0;
      minimo_q  <= '0;
      cont_q    <= '0;
      nmax_q    <= 1'b0;
      nmin_q    <= 1'b0;
    end else begin
      max_run_q <= max_run_d;
      min_run_q <= min_run_d;
      maximo_q  <= maximo_d;
      minimo_q  <= minimo_d;
      cont_q    <= cont_d;
      nmax_q    <= nmax_d;
      nmin_q    <= nmin_d;
    end
  end

  assign maximo      = maximo_q;
  assign minimo      = minimo_q;
  assign contagem    = cont_q;
  assign novo_maximo = nmax_q;
  assign novo_minimo = nmin_q;

endmodule

// File: tb/tb_rastreador_extremos.sv
// Testbench for rastreador_extremos: dut_a uses JANELA=4, dut_b JANELA=2.
module tb_rastreador_extremos;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;

  logic       valido_in_a, limpar_a, pronto_a, valido_out_a, nmax_a, nmin_a;
  logic [3:0] dado_a, maximo_a, minimo_a;
  logic [2:0] contagem_a;

  logic       valido_in_b, limpar_b, pronto_b, valido_out_b, nmax_b, nmin_b;
  logic [3:0] dado_b, maximo_b, minimo_b;
  logic [1:0] contagem_b;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       nmax;
    logic       nmin;
    logic [2:0] cnt;
  } amostra_t;

  typedef struct {
    logic [3:0] mx;
    logic [3:0] mn;
  } pub_t;

  amostra_t amostra_q[$];
  pub_t     pub_q[$];

  rastreador_extremos #(.LARGURA(4), .JANELA(4)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .valido_in   (valido_in_a),
    .dado        (dado_a),
    .pronto_out  (pronto_a),
    .limpar      (limpar_a),
    .maximo      (maximo_a),
    .minimo      (minimo_a),
    .valido_out  (valido_out_a),
    .novo_maximo (nmax_a),
    .novo_minimo (nmin_a),
    .contagem    (contagem_a)
  );

  rastreador_extremos #(.LARGURA(4), .JANELA(2)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .valido_in   (valido_in_b),
    .dado        (dado_b),
    .pronto_out  (pronto_b),
    .limpar      (limpar_b),
    .maximo      (maximo_b),
    .minimo      (minimo_b),
    .valido_out  (valido_out_b),
    .novo_maximo (nmax_b),
    .novo_minimo (nmin_b),
    .contagem    (contagem_b)
  );

  // Publish scoreboard for dut_a: every strobe must match the oldest expected publish.
  always @(negedge clk) begin
    pub_t e;
    if (valido_out_a === 1'b1) begin
      checks++;
      if (pub_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_publish maximo=%0d minimo=%0d required no valido_out", maximo_a, minimo_a);
      end else begin
        e = pub_q.pop_front();
        if (maximo_a !== e.mx || minimo_a !== e.mn) begin
          failures++;
          $display("FAIL publish maximo=%0d minimo=%0d required %0d %0d", maximo_a, minimo_a, e.mx, e.mn);
        end else begin
          $display("publish maximo=%0d minimo=%0d ok", maximo_a, minimo_a);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic v, input logic [3:0] d, input logic clr);
    valido_in_a = v;
    dado_a      = d;
    limpar_a    = clr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (maximo_a !== 4'd0 || minimo_a !== 4'd0 || valido_out_a !== 1'b0 || nmax_a !== 1'b0 ||
        nmin_a !== 1'b0 || contagem_a !== 3'd0 || pronto_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_a max=%0d min=%0d vo=%b nmax=%b nmin=%b cnt=%0d pronto=%b required all 0",
               maximo_a, minimo_a, valido_out_a, nmax_a, nmin_a, contagem_a, pronto_a);
    end else $display("reset_a outputs zero ok");
    checks++;
    if (pronto_b !== 1'b0 || valido_out_b !== 1'b0 || contagem_b !== 2'd0) begin
      failures++;
      $display("FAIL reset_b pronto=%b vo=%b cnt=%0d required 0 0 0", pronto_b, valido_out_b, contagem_b);
    end else $display("reset_b outputs zero ok");
    reset = 1'b1;
    #1;
    checks++;
    if (pronto_a !== 1'b1 || pronto_b !== 1'b1) begin
      failures++;
      $display("FAIL reset_release pronto_a=%b pronto_b=%b required 1 1", pronto_a, pronto_b);
    end else $display("reset_release pronto ok");
  endtask

  task automatic test_window();
    logic [3:0] d[4]  = '{4'd5, 4'd2, 4'd9, 4'd2};
    logic       em[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       en[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    amostra_t   e;
    for (int i = 0; i < 4; i++) begin
      amostra_q.push_back('{nmax: em[i], nmin: en[i], cnt: 3'(i + 1)});
      if (i == 3) pub_q.push_back('{mx: 4'd9, mn: 4'd2});
      step(1'b1, d[i], 1'b0);
      e = amostra_q.pop_front();
      checks++;
      if (nmax_a !== e.nmax || nmin_a !== e.nmin || contagem_a !== e.cnt) begin
        failures++;
        $display("FAIL window_sample%0d nmax=%b nmin=%b cnt=%0d required %b %b %0d",
                 i, nmax_a, nmin_a, contagem_a, e.nmax, e.nmin, e.cnt);
      end else $display("window sample %0d dado=%0d ok", i, d[i]);
    end
    checks++;
    if (valido_out_a !== 1'b1 || pronto_a !== 1'b0) begin
      failures++;
      $display("FAIL window_publish_cycle valido_out=%b pronto=%b required 1 0", valido_out_a, pronto_a);
    end else $display("window publish cycle ok");
  endtask

  task automatic test_back_to_back();
    // Held during PUBLICANDO: must not be taken there.
    step(1'b1, 4'd3, 1'b0);
    checks++;
    if (valido_out_a !== 1'b0 || contagem_a !== 3'd0 || pronto_a !== 1'b1 || maximo_a !== 4'd9 || minimo_a !== 4'd2) begin
      failures++;
      $display("FAIL backpressure_hold vo=%b cnt=%0d pronto=%b max=%0d min=%0d required 0 0 1 9 2",
               valido_out_a, contagem_a, pronto_a, maximo_a, minimo_a);
    end else $display("backpressure hold ok");
    step(1'b1, 4'd3, 1'b0);
    checks++;
    if (contagem_a !== 3'd1 || nmax_a !== 1'b1 || nmin_a !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_accept cnt=%0d nmax=%b nmin=%b required 1 1 1", contagem_a, nmax_a, nmin_a);
    end else $display("backpressure accept dado=3 ok");
  endtask

  task automatic test_clear();
    logic [3:0] d[4] = '{4'd6, 4'd6, 4'd6, 4'd6};
    step(1'b1, 4'd4, 1'b0);
    checks++;
    if (contagem_a !== 3'd2 || nmax_a !== 1'b1 || nmin_a !== 1'b0) begin
      failures++;
      $display("FAIL clear_pre4 cnt=%0d nmax=%b nmin=%b required 2 1 0", contagem_a, nmax_a, nmin_a);
    end else $display("clear pre dado=4 ok");
    step(1'b1, 4'd12, 1'b0);
    checks++;
    if (contagem_a !== 3'd3 || nmax_a !== 1'b1 || nmin_a !== 1'b0) begin
      failures++;
      $display("FAIL clear_pre12 cnt=%0d nmax=%b nmin=%b required 3 1 0", contagem_a, nmax_a, nmin_a);
    end else $display("clear pre dado=12 ok");
    step(1'b1, 4'd1, 1'b1);
    checks++;
    if (contagem_a !== 3'd0 || nmax_a !== 1'b0 || nmin_a !== 1'b0 || maximo_a !== 4'd9 ||
        minimo_a !== 4'd2 || valido_out_a !== 1'b0) begin
      failures++;
      $display("FAIL clear cnt=%0d nmax=%b nmin=%b max=%0d min=%0d vo=%b required 0 0 0 9 2 0",
               contagem_a, nmax_a, nmin_a, maximo_a, minimo_a, valido_out_a);
    end else $display("clear drop dado=1 ok");
    for (int i = 0; i < 4; i++) begin
      amostra_t e;
      amostra_q.push_back('{nmax: (i == 0), nmin: (i == 0), cnt: 3'(i + 1)});
      if (i == 3) pub_q.push_back('{mx: 4'd6, mn: 4'd6});
      step(1'b1, d[i], 1'b0);
      e = amostra_q.pop_front();
      checks++;
      if (nmax_a !== e.nmax || nmin_a !== e.nmin || contagem_a !== e.cnt) begin
        failures++;
        $display("FAIL equal_sample%0d nmax=%b nmin=%b cnt=%0d required %b %b %0d",
                 i, nmax_a, nmin_a, contagem_a, e.nmax, e.nmin, e.cnt);
      end else $display("equal window sample %0d ok", i);
    end
    step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [3:0] d[3] = '{4'd7, 4'd3, 4'd5};
    for (int i = 0; i < 3; i++) begin
      amostra_t e;
      amostra_q.push_back('{nmax: (i == 0), nmin: (i < 2), cnt: 3'(i + 1)});
      step(1'b1, d[i], 1'b0);
      e = amostra_q.pop_front();
      checks++;
      if (nmax_a !== e.nmax || nmin_a !== e.nmin || contagem_a !== e.cnt) begin
        failures++;
        $display("FAIL midreset_sample%0d nmax=%b nmin=%b cnt=%0d required %b %b %0d",
                 i, nmax_a, nmin_a, contagem_a, e.nmax, e.nmin, e.cnt);
      end else $display("mid-reset window sample %0d ok", i);
    end
    reset = 1'b0;
    valido_in_a = 1'b0;
    @(negedge clk);
    checks++;
    if (contagem_a !== 3'd0 || maximo_a !== 4'd0 || minimo_a !== 4'd0 || valido_out_a !== 1'b0 || pronto_a !== 1'b0) begin
      failures++;
      $display("FAIL midreset cnt=%0d max=%0d min=%0d vo=%b pronto=%b required 0 0 0 0 0",
               contagem_a, maximo_a, minimo_a, valido_out_a, pronto_a);
    end else $display("mid-reset cleared ok");
    reset = 1'b1;
    #1;
    step(1'b1, 4'd8, 1'b0);
    checks++;
    if (contagem_a !== 3'd1 || nmax_a !== 1'b1 || nmin_a !== 1'b1) begin
      failures++;
      $display("FAIL midreset_restart cnt=%0d nmax=%b nmin=%b required 1 1 1", contagem_a, nmax_a, nmin_a);
    end else $display("mid-reset restart dado=8 ok");
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_signedness();
    logic [3:0] exp_mx, exp_mn;
    logic       exp_nmax, exp_nmin;
`ifdef RASTREADOR_SINAL_EN
    exp_mx = 4'b0111; exp_mn = 4'b1000; exp_nmax = 1'b0; exp_nmin = 1'b1;
`else
    exp_mx = 4'b1000; exp_mn = 4'b0111; exp_nmax = 1'b1; exp_nmin = 1'b0;
`endif
    valido_in_b = 1'b1;
    dado_b = 4'b0111;
    @(negedge clk);
    checks++;
    if (contagem_b !== 2'd1 || nmax_b !== 1'b1 || nmin_b !== 1'b1) begin
      failures++;
      $display("FAIL sign_first cnt=%0d nmax=%b nmin=%b required 1 1 1", contagem_b, nmax_b, nmin_b);
    end else $display("sign first sample ok");
    dado_b = 4'b1000;
    @(negedge clk);
    checks++;
    if (valido_out_b !== 1'b1 || maximo_b !== exp_mx || minimo_b !== exp_mn || nmax_b !== exp_nmax || nmin_b !== exp_nmin) begin
      failures++;
      $display("FAIL sign_publish vo=%b max=%b min=%b nmax=%b nmin=%b required 1 %b %b %b %b",
               valido_out_b, maximo_b, minimo_b, nmax_b, nmin_b, exp_mx, exp_mn, exp_nmax, exp_nmin);
    end else $display("sign publish max=%b min=%b ok", maximo_b, minimo_b);
    valido_in_b = 1'b0;
    @(negedge clk);
    checks++;
    if (valido_out_b !== 1'b0 || maximo_b !== exp_mx || minimo_b !== exp_mn || contagem_b !== 2'd0) begin
      failures++;
      $display("FAIL sign_hold vo=%b max=%b min=%b cnt=%0d required 0 %b %b 0",
               valido_out_b, maximo_b, minimo_b, contagem_b, exp_mx, exp_mn);
    end else $display("sign hold ok");
  endtask

  initial begin
    reset = 1'b0;
    valido_in_a = 1'b0; dado_a = 4'd0; limpar_a = 1'b0;
    valido_in_b = 1'b0; dado_b = 4'd0; limpar_b = 1'b0;
    test_reset();
    test_window();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_signedness();
    @(negedge clk);
    checks++;
    if (pub_q.size() != 0) begin
      failures++;
      $display("FAIL missing_publish pending=%0d required 0", pub_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rastreador_extremos.md
# rastreador_extremos

Windowed max/min tracker that sits directly downstream of the 4-bit magnitude comparator. It accepts a stream of samples over a valid/ready handshake and compares each sample against running maximum and minimum registers. Every `JANELA` accepted samples it publishes the window's extremes for one cycle, then starts a new window. Typical use is range monitoring of sensor or counter values feeding later decision logic.

## Interface
- `LARGURA`, default 4: sample width in bits.
- `JANELA`, default 8: samples per window, ≥2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low; 0 = reset.
- `valido_in`  in  1  sample valid.
- `dado`  in  `LARGURA`  sample.
- `pronto_out`  out  1  ready; a sample is accepted on a rising edge with `valido_in && pronto_out`.
- `limpar`  in  1  synchronous abort of the current window.
- `maximo`, `minimo`  out  `LARGURA`  last published window extremes, held until the next publish.
- `valido_out`  out  1  one-cycle publish strobe.
- `novo_maximo`, `novo_minimo`  out  1  one-cycle pulse after an accepted sample set a new running extreme.
- `contagem`  out  `$clog2(JANELA+1)`  samples accepted in the current window.

## Operation
- FSM states:
  - VAZIO: no sample in the window yet.
  - ACUMULANDO.
  - PUBLICANDO.
- `pronto_out` = 1 in VAZIO and ACUMULANDO; 0 in PUBLICANDO and while `reset`=0.
- VAZIO + accept: running max = running min = `dado`; both `novo_*` pulse; `contagem`=1; go to ACUMULANDO.
- ACUMULANDO + accept:
  - Compare `dado` against running max and running min.
  - Strictly greater than the running max: replace it and pulse `novo_maximo`.
  - Strictly less than the running min: replace it and pulse `novo_minimo`.
  - Equal values: no update, no pulse.
  - `contagem`++.
- Accepting the `JANELA`-th sample goes to PUBLICANDO, with that sample included in the extremes.
- PUBLICANDO (exactly 1 cycle):
  - Load `maximo`/`minimo` from the running registers.
  - `valido_out`=1.
  - Next state VAZIO with `contagem`=0.
- `limpar`=1 in VAZIO/ACUMULANDO:
  - Any same-cycle sample is discarded, not accepted.
  - Running registers and `contagem` go to 0; state goes to VAZIO.
  - Published `maximo`/`minimo` are unchanged.
- `limpar` in PUBLICANDO is ignored; the publish completes.
- Comparison is unsigned by default. Extremes keep full `LARGURA`; there is no arithmetic and no overflow.

## Timing
- Reset values:
  - `maximo`=0, `minimo`=0.
  - `valido_out`=0, `novo_maximo`=0, `novo_minimo`=0.
  - `contagem`=0, `pronto_out`=0, state VAZIO.
- Reset mid-window discards all progress. `pronto_out`=1 on the first cycle after `reset` returns to 1.
- `novo_*` and `contagem` are registered and valid in the cycle after the accepting edge.
- `valido_out` rises in the cycle after the `JANELA`-th accepting edge. `maximo`/`minimo` change in that same cycle and hold afterward.
- Throughput: `JANELA` samples per `JANELA`+1 cycles; one bubble per window.
- `valido_in` held during PUBLICANDO is accepted on the following VAZIO cycle; the sample is not lost.

## Configuration
- `RASTREADOR_SINAL_EN` defined: `dado` and the extremes are two's-complement signed. For example, 4'b1000 (-8) is the smallest value and 4'b0111 (+7) the largest.
- Not defined: unsigned comparison; 4'b1000 (8) > 4'b0111 (7).
- All other behaviour is identical in both builds.

## Structure
- Package `rastreador_pkg` holds:
  - state enum `estado_t` {VAZIO, ACUMULANDO, PUBLICANDO};
  - default constants `LARGURA_PADRAO`=4 and `JANELA_PADRAO`=8.
- Sub-module `comparador_magnitude` #(`LARGURA`): purely combinational, outputs `igual`/`maior`/`menor` for `A` vs `B`.
  - Signedness follows `RASTREADOR_SINAL_EN`.
  - Instantiated twice: `dado` vs running max, and `dado` vs running min.

## Test plan
- Reset: hold `reset`=0 for 2 cycles -> all outputs 0, `pronto_out`=0; first cycle after release -> `pronto_out`=1.
- Window: `JANELA`=4, samples 5, 2, 9, 2 back-to-back -> `valido_out`=1 in the cycle after the 4th accept with `maximo`=9, `minimo`=2.
  - `novo_maximo` pulses after samples 5 and 9 only.
  - `novo_minimo` pulses after samples 5 and 2 (first occurrence) only.
- Backpressure: `valido_in` held with sample 3 during PUBLICANDO -> not accepted there; accepted next cycle as the first sample of the new window (`contagem`=1).
- Clear: samples 4, 12, then `limpar`=1 together with sample 1 -> sample 1 dropped, `contagem`=0, previously published `maximo`/`minimo` unchanged. Next window 6, 6, 6, 6 -> `maximo`=`minimo`=6.
- Signedness: `JANELA`=2, samples 4'b0111, 4'b1000 -> without the macro `maximo`=8, `minimo`=7; with `RASTREADOR_SINAL_EN`, `maximo`=7, `minimo`=-8.
- Reset mid-window: after 3 of 4 samples, assert `reset`=0 for 1 cycle -> `contagem`=0, `maximo`=`minimo`=0, no `valido_out`.
